// File: rtl/mdarray_pkg.sv
// Shared constants for the 3-D array scan controller: FSM state codes,
// output FIFO depth and storage read latency.
package mdarray_pkg;

    // Output FIFO depth; also the number of read credits in DRAIN.
    localparam int unsigned FifoDepth = 3;

    // Cycles from address presentation to rd_data valid.
    localparam int unsigned RdLatency = 2;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StFill  = 2'd1;
    localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/mdarray_out_fifo.sv
// Small synchronous FIFO holding read bytes on their way to the outbound
// stream. Push and pop in the same cycle are allowed; the caller guarantees
// it never pushes into a full FIFO without popping, nor pops when empty.
module mdarray_out_fifo
    import mdarray_pkg::*;
#(
    parameter int unsigned Depth = FifoDepth,
    parameter int unsigned DW    = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [DW-1:0]                  push_data,
    input  logic                           pop,
    output logic [DW-1:0]                  head,
    output logic [$clog2(Depth+1)-1:0]     count,
    output logic                           empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [DW-1:0]   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Pointer wrap and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/mdarray_scan_ctrl.sv
// Fill/drain controller for a cubic storage array of extent E = W+1 per axis.
// FILL writes the inbound stream to every address in col-fastest order; DRAIN
// reads the same addresses back (fixed read latency) through a small output
// FIFO, throttled by credits so the FIFO can never overflow.
module mdarray_scan_ctrl
    import mdarray_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [7:0]   m_data,
    output logic [W:0]   slc,
    output logic [W:0]   row,
    output logic [W:0]   col,
    output logic         wr,
    output logic [7:0]   wr_data,
    input  logic [7:0]   rd_data,
    output logic         busy,
    output logic         done
);

    localparam logic [W:0] LastIdx = (W+1)'(W);
    localparam logic [W:0] IdxOne  = (W+1)'(1);
    localparam int unsigned CntW   = $clog2(FifoDepth + 1);
    localparam int unsigned CrW    = $clog2(FifoDepth + RdLatency + 1);

    state_t               state_q, state_d;
    logic [W:0]           slc_q, slc_d;
    logic [W:0]           row_q, row_d;
    logic [W:0]           col_q, col_d;
    logic                 rd_all_q, rd_all_d;
    logic [RdLatency-1:0] pipe_q, pipe_d;
    logic                 done_q, done_d;

    logic                 at_last;
    logic                 step;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [CntW-1:0]      fifo_count;
    logic [CrW-1:0]       inflight;
    logic [CrW-1:0]       credits_used;

    assign at_last = (slc_q == LastIdx) && (row_q == LastIdx) && (col_q == LastIdx);

    // Count reads still travelling through the storage latency pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RdLatency); i++) begin
            inflight = inflight + CrW'(pipe_q[i]);
        end
    end

    // Read issue: the credit held by the FIFO head is returned in the cycle it
    // is popped, which lets three credits cover the full issue-to-pop loop and
    // keeps DRAIN at one beat per cycle while still bounding occupancy.
    always_comb begin
        credits_used = CrW'(fifo_count) + inflight - CrW'(pop);
        issue = (state_q == StDrain) && !rd_all_q && (credits_used < CrW'(FifoDepth));
    end

    assign step = ((state_q == StFill) && s_valid) || issue;

    // Scan counters: col fastest, then row, then slc; wraps to 0 after the last cell.
    always_comb begin
        slc_d = slc_q;
        row_d = row_q;
        col_d = col_q;
        if (step) begin
            if (col_q != LastIdx) begin
                col_d = col_q + IdxOne;
            end else begin
                col_d = '0;
                if (row_q != LastIdx) begin
                    row_d = row_q + IdxOne;
                end else begin
                    row_d = '0;
                    slc_d = (slc_q != LastIdx) ? slc_q + IdxOne : '0;
                end
            end
        end
    end

    // Read-valid pipeline; its tail lines up with rd_data.
    always_comb begin
        pipe_d = {pipe_q[RdLatency-2:0], issue};
    end

    // Pass sequencing: IDLE -> FILL -> DRAIN -> IDLE.
    always_comb begin
        state_d  = state_q;
        rd_all_d = rd_all_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // Ignore a start that coincides with the done pulse.
                if (start && !done_q) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (s_valid && at_last) begin
                    state_d  = StDrain;
                    rd_all_d = 1'b0;
                end
            end
            StDrain: begin
                if (issue && at_last) begin
                    rd_all_d = 1'b1;
                end
                if (rd_all_q && (pipe_q == '0) && fifo_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            slc_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rd_all_q <= 1'b0;
            pipe_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slc_q    <= slc_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_all_q <= rd_all_d;
            pipe_q   <= pipe_d;
            done_q   <= done_d;
        end
    end

    assign push = pipe_q[RdLatency-1];
    assign pop  = m_valid && m_ready;

    mdarray_out_fifo #(
        .Depth (FifoDepth),
        .DW    (8)
    ) u_out_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .head      (m_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign s_ready = (state_q == StFill);
    assign wr      = (state_q == StFill) && s_valid;
    assign wr_data = s_data;
    assign slc     = slc_q;
    assign row     = row_q;
    assign col     = col_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule

// File: tb/tb_mdarray_scan_ctrl.sv
// Directed-plus-random bench for mdarray_scan_ctrl with a behavioural storage
// array and an order-preserving expectation model.
module tb_mdarray_scan_ctrl;

    localparam int W = 2;
    localparam int E = W + 1;
    localparam int N = E * E * E;
    localparam int AW = 3 * (W + 1);

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_data;
    logic [W:0]   slc;
    logic [W:0]   row;
    logic [W:0]   col;
    logic         wr;
    logic [7:0]   wr_data;
    logic [7:0]   rd_data;
    logic         busy;
    logic         done;

    mdarray_scan_ctrl #(
        .W (W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .slc     (slc),
        .row     (row),
        .col     (col),
        .wr      (wr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Storage stage: write on wr, read data returned two cycles after address.
    logic [7:0] mem [N];
    int         a1;
    int         a2;

    function automatic int lin(input logic [W:0] s, input logic [W:0] r, input logic [W:0] c);
        return int'(s) * E * E + int'(r) * E + int'(c);
    endfunction

    always @(posedge clock) begin
        if (wr && lin(slc, row, col) < N) mem[lin(slc, row, col)] <= wr_data;
        a1 <= lin(slc, row, col);
        a2 <= a1;
    end
    assign rd_data = (a2 >= 0 && a2 < N) ? mem[a2] : 8'h00;

    // Monitor: logs writes and delivered bytes at the falling edge.
    logic [AW-1:0] wr_addr_q [$];
    logic [7:0]    wr_data_q [$];
    logic [7:0]    out_q [$];
    int            out_cyc_q [$];
    int            cyc;
    int            done_cnt;
    int            wr_bad;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (wr) begin
                wr_addr_q.push_back({slc, row, col});
                wr_data_q.push_back(wr_data);
                if (!s_valid) wr_bad++;
            end
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                out_cyc_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    int         n_cmp;
    int         n_err;
    logic [7:0] sent_q [$];
    int         wbase;
    int         obase;
    int         dbase;
    int         bbase;
    bit         rnd_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int k);
        return {(W+1)'(k / (E * E)), (W+1)'((k / E) % E), (W+1)'(k % E)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic new_pass(input bit counting);
        sent_q.delete();
        for (int k = 0; k < N; k++) sent_q.push_back(counting ? 8'(k) : 8'($urandom));
        wbase = wr_addr_q.size();
        obase = out_q.size();
        dbase = done_cnt;
        bbase = wr_bad;
    endtask

    // mode 0: back-to-back, 1: alternate valid, 2: random valid.
    task automatic fill(input int mode, input int start_at);
        int i;
        bit tog;
        i   = 0;
        tog = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (i < N) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = tog;
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            tog    = !tog;
            s_data = sent_q[i];
            start  = (i == start_at);
            tick();
            if (s_valid) i++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "/done_seen"}, 32'(done), 1);
    endtask

    task automatic check_pass(input string tag);
        tick();
        tick();
        check({tag, "/wr_count"}, wr_addr_q.size() - wbase, N);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s/wr_addr[%0d]", tag, k), 32'(wr_addr_q[wbase + k]), 32'(exp_addr(k)));
            check($sformatf("%s/wr_data[%0d]", tag, k), 32'(wr_data_q[wbase + k]), 32'(sent_q[k]));
        end
        check({tag, "/out_count"}, out_q.size() - obase, N);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s/m_data[%0d]", tag, k), 32'(out_q[obase + k]), 32'(sent_q[k]));
        end
        check({tag, "/done_pulses"}, done_cnt - dbase, 1);
        check({tag, "/busy_after"}, 32'(busy), 0);
        check({tag, "/wr_without_valid"}, wr_bad - bbase, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "/s_ready"}, 32'(s_ready), 0);
        check({tag, "/wr"}, 32'(wr), 0);
        check({tag, "/m_valid"}, 32'(m_valid), 0);
        check({tag, "/busy"}, 32'(busy), 0);
        check({tag, "/done"}, 32'(done), 0);
        check({tag, "/addr"}, 32'({slc, row, col}), 0);
    endtask

    initial begin
        clock     = 1'b0;
        reset_n   = 1'b0;
        start     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        m_ready   = 1'b0;
        rnd_ready = 1'b0;
        n_cmp     = 0;
        n_err     = 0;

        #12;
        check_reset_values("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // A: bytes 0..26 back-to-back, sink always ready.
        new_pass(1'b1);
        m_ready = 1'b1;
        fill(0, -1);
        wait_done("A");
        check_pass("A");
        if (out_cyc_q.size() >= obase + N) begin
            check("A/drain_rate", out_cyc_q[obase + N - 1] - out_cyc_q[obase], N - 1);
        end

        // B: s_valid alternating, random bytes.
        new_pass(1'b0);
        fill(1, -1);
        wait_done("B");
        check_pass("B");

        // C: sink stalled for 10 cycles in DRAIN; only three reads may issue.
        new_pass(1'b0);
        m_ready = 1'b0;
        fill(0, -1);
        repeat (10) tick();
        check("C/stalled_addr", 32'({slc, row, col}), 32'(exp_addr(3)));
        check("C/m_valid_full", 32'(m_valid), 1);
        check("C/m_data_head", 32'(m_data), 32'(sent_q[0]));
        check("C/busy_stalled", 32'(busy), 1);
        m_ready = 1'b1;
        wait_done("C");
        check_pass("C");

        // D: random sink backpressure and random source gaps.
        new_pass(1'b0);
        rnd_ready = 1'b1;
        fill(2, -1);
        wait_done("D");
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        check_pass("D");

        // E: asynchronous reset during the 14th write, then a fresh pass.
        new_pass(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            s_valid = 1'b1;
            s_data  = sent_q[k];
            tick();
        end
        s_valid = 1'b1;
        s_data  = sent_q[13];
        #1;
        check("E/wr14", 32'(wr), 1);
        check("E/addr14", 32'({slc, row, col}), 32'(exp_addr(13)));
        reset_n = 1'b0;
        #1;
        check_reset_values("E/async");
        s_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        new_pass(1'b0);
        fill(0, -1);
        wait_done("E");
        check_pass("E");

        // F: start during FILL and coincident with done must be ignored.
        new_pass(1'b0);
        fill(0, 5);
        wait_done("F");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_pass("F");
        repeat (3) tick();
        check("F/still_idle", 32'(busy), 0);
        check("F/no_extra_done", done_cnt - dbase, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
